// File: rtl/c_gather_pack_if.sv
// Stream bundle for c_gather_pack: masked-input beats in, packed words out.
// Handshake: a beat/word transfers on a rising edge where valid & ready; valid never waits on ready, and valid and its payload hold until that transfer.
interface c_gather_pack_if #(
  parameter int in_width  = 32,
  parameter int out_width = 32
);
  localparam int ocnt_width = $clog2(out_width + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [0:in_width-1]   data_in;
  logic [0:in_width-1]   mask_in;
  logic                  flush_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:out_width-1]  data_out;
  logic [0:ocnt_width-1] out_count;
  logic                  out_last;

  modport master (
    output in_valid, data_in, mask_in, flush_in, out_ready,
    input  in_ready, out_valid, data_out, out_count, out_last
  );

  modport slave (
    input  in_valid, data_in, mask_in, flush_in, out_ready,
    output in_ready, out_valid, data_out, out_count, out_last
  );
endinterface

// File: rtl/c_gather_pack.sv
// Runtime-mask bit gather and packer: masked bits of each beat are appended to a bit stream and emitted as out_width words.
// Optional C_GATHER_PACK_STATS_EN adds saturating bit_total / word_total counters.
module c_gather_pack #(
  parameter int in_width  = 32,
  parameter int out_width = 32
) (
  input  logic                clk,
  input  logic                reset,
  c_gather_pack_if.slave      bus,
  output logic                o_state
`ifdef C_GATHER_PACK_STATS_EN
  ,
  output logic [0:31]         bit_total,
  output logic [0:31]         word_total
`endif
);
  localparam int cnt_width  = $clog2(out_width + in_width);
  localparam int ocnt_width = $clog2(out_width + 1);
  localparam int acc_width  = out_width + in_width - 1;
  localparam int k_width    = $clog2(in_width + 1);
  localparam logic [cnt_width-1:0] OW_C = cnt_width'(out_width);

  typedef enum logic {ACCEPT = 1'b0, DRAIN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [0:acc_width-1]  r_acc;
  logic [cnt_width-1:0]  r_cnt;

  logic [0:in_width-1]   w_gath;
  logic [k_width-1:0]    w_k;
  logic [0:acc_width-1]  w_g_ext;
  logic [0:acc_width-1]  w_acc_ins;
  logic [0:acc_width-1]  w_acc_shift;
  logic [cnt_width-1:0]  w_take;
  logic [0:out_width-1]  w_keep;
  logic                  w_in_ready;
  logic                  w_out_valid;
  logic [0:out_width-1]  w_data_out;
  logic [0:ocnt_width-1] w_out_count;
  logic                  w_out_last;
  logic                  w_in_fire;
  logic                  w_out_fire;

  // Compact the selected bits to the low indices, preserving data_in order.
  always_comb begin
    int n;
    n      = 0;
    w_gath = '0;
    for (int i = 0; i < in_width; i++) begin
      if (bus.mask_in[i]) begin
        w_gath[n] = bus.data_in[i];
        n = n + 1;
      end
    end
    w_k = k_width'(n);
  end

  always_comb begin
    w_g_ext = '0;
    for (int i = 0; i < in_width; i++) w_g_ext[i] = w_gath[i];
  end

  // Bits at index >= r_cnt are always zero, so OR-ing in at offset r_cnt is an append.
  assign w_acc_ins   = r_acc | (w_g_ext >> r_cnt);
  assign w_acc_shift = r_acc << out_width;
  assign w_take      = (r_cnt >= OW_C) ? OW_C : r_cnt;

  always_comb begin
    w_keep = '0;
    for (int i = 0; i < out_width; i++) w_keep[i] = (cnt_width'(i) < r_cnt);
  end

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_in_fire) begin
      r_acc <= w_acc_ins;
      r_cnt <= r_cnt + cnt_width'(w_k);
    end else if (w_out_fire) begin
      r_acc <= w_acc_shift;
      r_cnt <= r_cnt - w_take;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ACCEPT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCEPT: if (w_in_fire && bus.flush_in) w_state_next = DRAIN;
      DRAIN: begin
        if (r_cnt == '0)                   w_state_next = ACCEPT;
        else if (w_out_fire && w_out_last) w_state_next = ACCEPT;
      end
      default: w_state_next = ACCEPT;
    endcase
  end

  // Outputs read zero whenever no word is offered, including throughout reset.
  always_comb begin
    w_in_ready  = (r_state == ACCEPT) && (r_cnt < OW_C);
    w_out_valid = 1'b0;
    w_data_out  = '0;
    w_out_count = '0;
    w_out_last  = 1'b0;
    if (reset) begin
      case (r_state)
        ACCEPT: begin
          if (r_cnt >= OW_C) begin
            w_out_valid = 1'b1;
            w_data_out  = r_acc[0:out_width-1];
            w_out_count = ocnt_width'(out_width);
          end
        end
        DRAIN: begin
          if (r_cnt != '0) begin
            w_out_valid = 1'b1;
            w_data_out  = r_acc[0:out_width-1] & w_keep;
            w_out_count = ocnt_width'(w_take);
            w_out_last  = (r_cnt <= OW_C);
          end
        end
        default: w_out_valid = 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.data_out  = w_data_out;
  assign bus.out_count = w_out_count;
  assign bus.out_last  = w_out_last;
  assign o_state       = r_state;

`ifdef C_GATHER_PACK_STATS_EN
  logic [31:0] r_bit_total;
  logic [31:0] r_word_total;
  logic [32:0] w_bit_sum;

  assign w_bit_sum = {1'b0, r_bit_total} + 33'(w_k);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit_total  <= '0;
      r_word_total <= '0;
    end else begin
      if (w_in_fire) r_bit_total <= w_bit_sum[32] ? 32'hFFFF_FFFF : w_bit_sum[31:0];
      if (w_out_fire && (r_word_total != 32'hFFFF_FFFF)) r_word_total <= r_word_total + 32'd1;
    end
  end

  assign bit_total  = r_bit_total;
  assign word_total = r_word_total;
`endif
endmodule

// File: tb/tb_c_gather_pack.sv
// Directed bench for c_gather_pack (8-bit in, 8-bit out): hand-computed words go to an expected queue,
// a negedge monitor pops on every output transfer; extra point checks cover ready/valid timing.
module tb_c_gather_pack;
  localparam int IW = 8;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic reset;
  logic o_state;

  c_gather_pack_if #(.in_width(IW), .out_width(OW)) bus ();

`ifdef C_GATHER_PACK_STATS_EN
  logic [0:31] bit_total;
  logic [0:31] word_total;
`endif

  c_gather_pack #(.in_width(IW), .out_width(OW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .o_state (o_state)
`ifdef C_GATHER_PACK_STATS_EN
    ,
    .bit_total  (bit_total),
    .word_total (word_total)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];   // {data[7:0], count[3:0], last}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [7:0] d, input logic [3:0] c, input logic l);
    exp_q.push_back({d, c, l});
  endtask

  // driver: present a beat at posedge+1, hold until accepted
  task automatic send(input logic [7:0] d, input logic [7:0] m, input logic f);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.mask_in  = m;
    bus.flush_in = f;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 (data %0h)", d);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!(bus.in_ready && !bus.out_valid) && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!(bus.in_ready && !bus.out_valid)) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: in_ready %0b out_valid %0b expected 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got data %0h count %0d last %0b expected no word",
                 bus.data_out, bus.out_count, bus.out_last);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({bus.data_out, bus.out_count, bus.out_last} !== e) begin
          n_err++;
          $display("FAIL word: got data %0h count %0d last %0b expected data %0h count %0d last %0b",
                   bus.data_out, bus.out_count, bus.out_last, e[12:5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.mask_in   = '0;
    bus.flush_in  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_data_out",  bus.data_out,  0);
    check("rst_out_last",  bus.out_last,  0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready",  bus.in_ready,  1);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_state",     o_state,       0);
    @(posedge clk); #1;

    // full-mask single word, one-cycle latency
    expect_word(8'hF0, 4'd8, 1'b0);
    send(8'hF0, 8'hFF, 1'b0);
    @(negedge clk);
    check("t1_latency_valid", bus.out_valid, 1);
    wait_idle();

    // two half beats form one word; in_ready low while word is pending
    expect_word(8'hAA, 4'd8, 1'b0);
    send(8'hAA, 8'hF0, 1'b0);
    send(8'hAA, 8'hF0, 1'b0);
    @(negedge clk);
    check("t2_full_in_ready",  bus.in_ready,  0);
    check("t2_full_out_valid", bus.out_valid, 1);
    @(negedge clk);
    check("t2_after_fire_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    wait_idle();

    // cnt 4 + 8 bits with backpressure: word A3 held, leftover 1100 flushed
    send(8'hA5, 8'hF0, 1'b0);
    bus.out_ready = 1'b0;
    send(8'h3C, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid",    bus.out_valid, 1);
      check("t3_hold_data",     bus.data_out,  8'hA3);
      check("t3_hold_count",    bus.out_count, 8);
      check("t3_hold_last",     bus.out_last,  0);
      check("t3_hold_in_ready", bus.in_ready,  0);
    end
    @(posedge clk); #1;
    expect_word(8'hA3, 4'd8, 1'b0);
    bus.out_ready = 1'b1;
    expect_word(8'hC0, 4'd4, 1'b1);
    send(8'h00, 8'h00, 1'b1);
    wait_idle();

    // 3-bit flush from empty, then back in ACCEPT
    expect_word(8'hE0, 4'd3, 1'b1);
    send(8'hE0, 8'hE0, 1'b1);
    @(negedge clk);
    check("t4_drain_state", o_state, 1);
    @(negedge clk);
    check("t4_accept_state", o_state,      0);
    check("t4_in_ready",     bus.in_ready, 1);
    @(posedge clk); #1;

    // empty flush: no word, ready returns after DRAIN cycle
    send(8'hFF, 8'h00, 1'b1);
    @(negedge clk);
    check("t5_empty_in_ready",  bus.in_ready,  0);
    check("t5_empty_out_valid", bus.out_valid, 0);
    @(negedge clk);
    check("t5_empty_back_ready", bus.in_ready, 1);
    check("t5_empty_state",      o_state,      0);
    @(posedge clk); #1;

    // flush landing exactly on a word boundary
    expect_word(8'h5A, 4'd8, 1'b1);
    send(8'h5A, 8'hFF, 1'b1);
    wait_idle();
    check("t5_boundary_state", o_state, 0);

    // flush with 12 bits buffered: full word then 4-bit last word
    expect_word(8'hF6, 4'd8, 1'b0);
    expect_word(8'h90, 4'd4, 1'b1);
    send(8'hF0, 8'hF0, 1'b0);
    send(8'h69, 8'hFF, 1'b1);
    wait_idle();

    // reset with 5 bits pending in DRAIN discards them
    bus.out_ready = 1'b0;
    send(8'hF8, 8'hF8, 1'b1);
    @(negedge clk);
    check("t6_pending_valid", bus.out_valid, 1);
    check("t6_pending_count", bus.out_count, 5);
    check("t6_pending_last",  bus.out_last,  1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_in_reset_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6_after_reset_valid", bus.out_valid, 0);
    check("t6_after_reset_ready", bus.in_ready,  1);
    @(posedge clk); #1;
    expect_word(8'hC3, 4'd8, 1'b0);
    send(8'hC3, 8'hFF, 1'b0);
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/c_gather_pack.md
Name: c_gather_pack

Overview:
- Runtime-mask successor to the static bit-gather block.
- Each accepted input word is compacted under a per-beat mask (selected bits concatenated, index 0 first).
- Gathered bits are appended to a bit-stream accumulator; full out_width words are emitted over a valid/ready handshake.
- Used in packet header/flit packing paths where the field selection varies per beat; a flush sideband drains a final partial word.

Parameters:
- in_width, 32, width of input word and of the mask.
- out_width, 32, width of packed output word; >= 1.
- cnt_width, clog2(out_width+in_width), width of internal fill counter (derived, localparam).
- ocnt_width, clog2(out_width+1), width of out_count (derived, localparam).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- data_in  input  [0:in_width-1]  input word.
- mask_in  input  [0:in_width-1]  bits of data_in to gather on this beat.
- flush_in  input  1  last beat of stream; qualified by in_valid.
- out_valid  output  1  packed word available.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- data_out  output  [0:out_width-1]  packed word, bit 0 = oldest gathered bit.
- out_count  output  [0:ocnt_width-1]  number of valid bits in data_out (out_width except last word).
- out_last  output  1  final word of a flushed stream.

Behaviour:
- State: accumulator acc[0:out_width+in_width-2], fill count cnt, FSM {ACCEPT, DRAIN}.
- Reset (reset==0 at edge): acc=0, cnt=0, state=ACCEPT. in_valid/out_ready ignored while reset is 0.
- Reset mid-stream discards all buffered bits; no partial output is emitted.
- Output values while reset is 0 and after reset: out_valid=0, out_last=0, out_count=0, data_out=0.
- in_ready = (state==ACCEPT) & (cnt < out_width). Combinational from state only, never from in_valid.
- Input fire:
  - k = popcount(mask_in), range 0..in_width.
  - Gathered bits go to acc[cnt .. cnt+k-1] in ascending data_in index order; cnt += k.
  - If flush_in=1, state -> DRAIN.
  - k=0 is legal: cnt is unchanged and the flush still takes effect.
- ACCEPT:
  - out_valid = (cnt >= out_width); data_out = acc[0:out_width-1]; out_count = out_width; out_last=0.
- DRAIN:
  - out_valid = (cnt > 0); out_last = (cnt <= out_width); out_count = min(cnt, out_width).
  - Bits of data_out at index >= cnt are driven 0.
- Output fire:
  - acc shifts toward index 0 by out_width, zero-filled; cnt -= min(cnt, out_width).
  - If out_last, state -> ACCEPT.
- DRAIN with cnt==0 (empty flush, or flush landing exactly on a word boundary after that word drains): no output; state -> ACCEPT next cycle.
- Input fire and output fire are mutually exclusive by construction. In ACCEPT, in_ready needs cnt<out_width while out_valid needs cnt>=out_width; in DRAIN, in_ready=0.
- Latency: a beat completing a word at edge N gives out_valid=1 in cycle N+1. No combinational path from in_valid to out_valid or from out_ready to in_ready.
- Max cnt = out_width+in_width-1; no overflow possible.
- Backpressure: out_valid, data_out, out_count and out_last hold stable while out_valid & !out_ready.

Optional Feature:
- C_GATHER_PACK_STATS_EN.
- Defined: adds output bit_total [0:31], a saturating count of gathered bits (sum of k over input fires).
  - Cleared by reset; sticks at 32'hFFFFFFFF.
  - Also adds output word_total [0:31], a saturating count of output fires.
- Undefined: neither port nor its counters exist; behaviour is otherwise identical.

Test Plan (in_width=8, out_width=8):
- After reset release: in_ready=1, out_valid=0. Input 8'hF0 with mask 8'hFF, no flush -> next cycle out_valid=1, data_out=8'hF0, out_count=8, out_last=0.
- Beats data 8'b1010_1010, mask 8'hF0 twice -> one word 8'b1010_1010. in_ready=0 until that word fires.
- Beat mask 8'hFF with cnt=4 -> cnt=12 → first word fires, leftover 4 bits remain; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
- Beat data 8'b1110_0000, mask 8'hE0, flush=1 from empty -> data_out=8'b1110_0000, out_count=3, out_last=1. The following cycle is back in ACCEPT.
- Flush beat with mask 8'h00 and cnt=0 -> no output, in_ready returns 1 two cycles later. Flush with cnt=8 -> one word with out_count=8 and out_last=1.
- Assert reset=0 while cnt=5 and out_valid=1 -> next cycle out_valid=0, cnt=0. A subsequent 8-bit beat emits only the new bits.
